// File: rtl/lcd_cmd_seq.sv
// rtl/lcd_cmd_seq.sv - LCD image command sequencer: host FIFO, busy handshake, timeout and frame-end tracking.
module lcd_cmd_seq #(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [3:0]                    host_cmd,
   input  logic                          host_push,
   output logic                          host_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          busy,
   input  logic                          done,
   output logic [3:0]                    cmd,
   output logic                          cmd_valid,
   output logic                          seq_done,
   output logic [7:0]                    issued_cnt,
   output logic [7:0]                    drop_cnt,
   output logic                          timeout_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ACK,
      WAIT_RDY,
      DRAIN,
      FINISH
   } state_t;

   state_t          state, state_n;
   logic [3:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   level;
   logic [7:0]      to_cnt;

   logic            fifo_empty;
   logic            push_ok;
   logic            pop;
   logic            issue;
   logic            drop;
   logic            to_clr;
   logic            to_inc;
   logic            to_hit;
   logic            seq_set;
   logic [3:0]      head;
   logic            head_illegal;

   assign fifo_empty   = (level == '0);
   assign host_full    = (level == FULL_LVL);
   assign fifo_level   = level;
   assign head         = mem[rd_ptr];
   assign head_illegal = (head >= 4'hD);

   // A full FIFO still takes a push when the same cycle pops an entry.
   assign push_ok = host_push && (!host_full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= host_cmd;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (host_push && !push_ok) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      issue   = 1'b0;
      drop    = 1'b0;
      to_clr  = 1'b0;
      to_inc  = 1'b0;
      to_hit  = 1'b0;
      seq_set = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && !busy) begin
               pop = 1'b1;
               if (head_illegal) begin
                  drop = 1'b1;
               end else begin
                  issue = 1'b1;
                  if (head == 4'h0) begin
                     state_n = DRAIN;
                  end else begin
                     state_n = WAIT_ACK;
                     to_clr  = 1'b1;
                  end
               end
            end
         end
         WAIT_ACK: begin
            if (busy) begin
               state_n = WAIT_RDY;
            end else if (to_cnt == TO_LAST) begin
               to_hit  = 1'b1;
               state_n = IDLE;
            end else begin
               to_inc = 1'b1;
            end
         end
         WAIT_RDY: begin
            if (!busy) begin
               state_n = IDLE;
            end
         end
         DRAIN: begin
            if (done) begin
               seq_set = 1'b1;
               state_n = FINISH;
            end
         end
         FINISH: begin
            state_n = FINISH;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (to_clr) begin
         to_cnt <= '0;
      end else if (to_inc || to_hit) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // cmd is held between issues because the controller samples it while busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd         <= 4'h0;
         cmd_valid   <= 1'b0;
         issued_cnt  <= 8'd0;
         drop_cnt    <= 8'd0;
         seq_done    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         cmd_valid <= issue;
         if (issue) begin
            cmd <= head;
            if (issued_cnt != 8'hFF) begin
               issued_cnt <= issued_cnt + 1'b1;
            end
         end
         if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
         if (seq_set) begin
            seq_done <= 1'b1;
         end
         if (to_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb/tb_lcd_cmd_seq.sv - scoreboard bench for lcd_cmd_seq with a busy-responder controller model.
module tb_lcd_cmd_seq;

   localparam int DEPTH = 8;
   localparam int TO    = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] host_cmd = 4'h0;
   logic       host_push = 1'b0;
   logic       host_full;
   logic [3:0] fifo_level;
   logic       overflow;
   logic       busy;
   logic       done = 1'b0;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       seq_done;
   logic [7:0] issued_cnt;
   logic [7:0] drop_cnt;
   logic       timeout_err;

   logic       resp_en = 1'b0;
   logic       busy_resp = 1'b0;
   logic       busy_force = 1'b0;
   logic       prev_valid = 1'b0;
   logic [3:0] exp_q[$];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fails = 0;

   assign busy = busy_resp | busy_force;

   lcd_cmd_seq #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_push(host_push),
      .host_full(host_full), .fifo_level(fifo_level), .overflow(overflow),
      .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
      .seq_done(seq_done), .issued_cnt(issued_cnt), .drop_cnt(drop_cnt),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every issue must match the head of the expected-command queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && cmd_valid) begin
            check("cmd_valid_one_cycle", prev_valid, 0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL unexpected_issue: cmd=%0d issued, nothing expected (cycle %0d)", cmd, cyc);
            end else begin
               check("cmd_order", cmd, exp_q.pop_front());
            end
         end
         prev_valid = cmd_valid;
      end
   end

   // Controller model: raise busy for two cycles after each strobe.
   initial begin
      forever begin
         @(negedge clk);
         if (resp_en && cmd_valid) begin
            busy_resp = 1'b1;
            repeat (2) @(negedge clk);
            busy_resp = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [3:0] c, input bit exp_issue);
      host_cmd  = c;
      host_push = 1'b1;
      if (exp_issue) exp_q.push_back(c);
      @(negedge clk);
      host_push = 1'b0;
   endtask

   task automatic wait_issue(output int at, input int bound);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (cmd_valid) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check("issue_seen", 0, 1);
   endtask

   initial begin
      int t0, t1, t2, t_to, ta, tz;

      repeat (2) @(negedge clk);
      reset = 1'b0;

      check("rst_cmd", cmd, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_level", fifo_level, 0);
      check("rst_full", host_full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_seq_done", seq_done, 0);
      check("rst_issued", issued_cnt, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_timeout", timeout_err, 0);

      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("done_ignored_idle", seq_done, 0);

      // Issue with handshake
      resp_en = 1'b1;
      push(4'h1, 1);
      push(4'h4, 1);
      push(4'h5, 1);
      repeat (20) @(negedge clk);
      check("hs_issued", issued_cnt, 3);
      check("hs_cmd_hold", cmd, 5);
      check("hs_level", fifo_level, 0);

      // Reference latency without a drop, then with one illegal entry ahead
      busy_force = 1'b1;
      push(4'h3, 1);
      busy_force = 1'b0;
      t0 = cyc;
      wait_issue(t1, 10);
      check("lat_no_drop", t1 - t0, 1);
      repeat (10) @(negedge clk);

      busy_force = 1'b1;
      push(4'hE, 0);
      push(4'h3, 1);
      busy_force = 1'b0;
      t0 = cyc;
      wait_issue(t1, 10);
      check("lat_with_drop", t1 - t0, 2);
      repeat (10) @(negedge clk);
      check("drop_cnt", drop_cnt, 1);
      check("drop_issued", issued_cnt, 5);

      // FIFO full and overflow
      busy_force = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         if (i == 9) check("ovf_before", overflow, 0);
         push(4'(i), i <= 8);
         if (i == 7) check("full_after_7", host_full, 0);
         if (i == 8) check("full_after_8", host_full, 1);
      end
      check("ovf_set", overflow, 1);
      check("ovf_level", fifo_level, 8);
      busy_force = 1'b0;
      repeat (50) @(negedge clk);
      check("ovf_issued", issued_cnt, 13);
      check("ovf_drained", fifo_level, 0);
      check("ovf_sticky", overflow, 1);

      // Timeout: controller never acknowledges 0x2
      resp_en = 1'b0;
      push(4'h2, 1);
      wait_issue(t1, 10);
      push(4'h7, 1);
      t_to = -1000;
      for (int i = 0; i < 300; i++) begin
         if (timeout_err) begin
            t_to = cyc;
            break;
         end
         @(negedge clk);
      end
      check("timeout_cycles", t_to - t1, TO);
      resp_en = 1'b1;
      wait_issue(t2, 10);
      check("after_timeout_issue", t2 - t_to, 1);
      repeat (10) @(negedge clk);
      check("timeout_issued", issued_cnt, 15);
      check("timeout_sticky", timeout_err, 1);

      // Frame end
      busy_force = 1'b1;
      push(4'h8, 1);
      push(4'h0, 1);
      push(4'h6, 0);
      busy_force = 1'b0;
      wait_issue(ta, 10);
      wait_issue(tz, 20);
      repeat (9) @(negedge clk);
      check("seq_done_early", seq_done, 0);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("seq_done_set", seq_done, 1);
      repeat (20) @(negedge clk);
      check("finish_level", fifo_level, 1);
      check("finish_issued", issued_cnt, 17);
      push(4'h1, 0);
      check("push_in_finish", fifo_level, 2);

      // Reset mid-operation in WAIT_RDY
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_leaves_finish", seq_done, 0);
      busy_force = 1'b1;
      push(4'h1, 1);
      push(4'h2, 0);
      push(4'h3, 0);
      push(4'h4, 0);
      busy_force = 1'b0;
      wait_issue(t1, 10);
      @(negedge clk);
      check("wait_rdy_level", fifo_level, 3);
      reset = 1'b1;
      #1;
      check("async_rst_cmd", cmd, 0);
      check("async_rst_valid", cmd_valid, 0);
      check("async_rst_level", fifo_level, 0);
      check("async_rst_issued", issued_cnt, 0);
      check("async_rst_full", host_full, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("post_rst_level", fifo_level, 0);
      check("post_rst_issued", issued_cnt, 0);
      push(4'hC, 1);
      repeat (10) @(negedge clk);
      check("post_rst_new_issue", issued_cnt, 1);
      check("post_rst_cmd", cmd, 4'hC);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
